// File: rtl/memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// memory_access_unit_if
// Bundles the three signal groups around the memory access unit:
//   request  : reqValid/reqReady handshake plus reqOp, reqAddress, reqData,
//              reqDest (execute stage -> unit)
//   memory   : memEnable, memAddress, memDataInput (unit -> memory),
//              memDataOutput (memory -> unit)
//   response : rspValid/rspReady handshake plus rspData, rspDest, rspError
//              (unit -> writeback)
// Modports:
//   slave  - the unit's view (accepts requests, drives memory and response)
//   master - the environment's view (execute stage, memory and writeback)
// -----------------------------------------------------------------------------
interface memory_access_unit_if #(
   parameter int DEST_WIDTH = 3
);
   logic                  reqValid;
   logic                  reqReady;
   logic [1:0]            reqOp;
   logic [7:0]            reqAddress;
   logic [7:0]            reqData;
   logic [DEST_WIDTH-1:0] reqDest;

   logic                  memEnable;
   logic [7:0]            memAddress;
   logic [7:0]            memDataInput;
   logic [7:0]            memDataOutput;

   logic                  rspValid;
   logic                  rspReady;
   logic [7:0]            rspData;
   logic [DEST_WIDTH-1:0] rspDest;
   logic                  rspError;

   modport slave (
      input  reqValid, reqOp, reqAddress, reqData, reqDest, rspReady, memDataOutput,
      output reqReady, memEnable, memAddress, memDataInput, rspValid, rspData, rspDest,
             rspError
   );

   modport master (
      output reqValid, reqOp, reqAddress, reqData, reqDest, rspReady, memDataOutput,
      input  reqReady, memEnable, memAddress, memDataInput, rspValid, rspData, rspDest,
             rspError
   );
endinterface

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// Sequences one load / store / swap at a time against an 8-bit data memory
// with a registered read port, and returns the read value plus destination
// tag to writeback. Out-of-range addresses and the reserved opcode are
// answered with an error response without touching memory.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-low reset
//   bus      - memory_access_unit_if.slave (request, memory, response groups)
//   busy     - high whenever the unit is not IDLE
//   state_o  - current FSM state (IDLE=0 READ=1 CAPTURE=2 WRITE=3 RESP=4)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and its payload stable until that edge;
// ready may be asserted independently of valid.
// -----------------------------------------------------------------------------
module memory_access_unit #(
   parameter int MEM_DEPTH  = 33,
   parameter int DEST_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   memory_access_unit_if.slave        bus,
   output logic                       busy,
   output logic [2:0]                 state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CAPTURE = 3'd2,
      S_WRITE   = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b10;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [7:0]            addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic [7:0]            rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  req_err;

   assign req_err = (bus.reqOp == 2'b11) || (32'(bus.reqAddress) >= 32'(MEM_DEPTH));

   // State register and request latches
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dest_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dest_q  <= dest_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and latch update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dest_d  = dest_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.reqValid) begin
               op_d    = bus.reqOp;
               addr_d  = bus.reqAddress;
               wdata_d = bus.reqData;
               dest_d  = bus.reqDest;
               // Cleared so stores and errors answer with zero data
               rdata_d = '0;
               err_d   = req_err;
               if (req_err)                    state_d = S_RESP;
               else if (bus.reqOp == OP_STORE) state_d = S_WRITE;
               else                            state_d = S_READ;
            end
         end
         S_READ:    state_d = S_CAPTURE;
         S_CAPTURE: begin
            // Memory registered the read address at the end of READ
            rdata_d = bus.memDataOutput;
            state_d = (op_q == OP_SWAP) ? S_WRITE : S_RESP;
         end
         S_WRITE:   state_d = S_RESP;
         S_RESP: begin
            if (bus.rspReady) state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs. Strobes are gated with rst so nothing fires on a reset edge.
   always_comb begin
      bus.reqReady     = 1'b0;
      bus.memEnable    = 1'b0;
      bus.memAddress   = '0;
      bus.memDataInput = '0;
      bus.rspValid     = 1'b0;
      unique case (state_q)
         S_IDLE:    bus.reqReady = rst;
         // The memory takes its read address on the data-input pins
         S_READ:    bus.memDataInput = addr_q;
         S_CAPTURE: bus.memDataInput = addr_q;
         S_WRITE: begin
            bus.memEnable    = rst;
            bus.memAddress   = addr_q;
            bus.memDataInput = wdata_q;
         end
         S_RESP:    bus.rspValid = rst;
         default:   ;
      endcase
   end

   assign bus.rspData  = rdata_q;
   assign bus.rspDest  = dest_q;
   assign bus.rspError = err_q;
   assign busy         = (state_q != S_IDLE);
   assign state_o      = state_q;

   // op_q only steers the CAPTURE exit; load/store are implied by the path taken
   logic unused_ok;
   assign unused_ok = ^{OP_LOAD};

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
// Directed bench: a behavioural 256-word memory with a registered read port
// sits on the memory pins; expected values are written inline as constants.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;

   localparam int DW = 3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_READ    = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_WRITE   = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       busy;
   logic [2:0] state;

   int vectors    = 0;
   int miscompares = 0;
   int wr_count   = 0;
   int wr_snap;

   logic [7:0] mem [256];

   memory_access_unit_if #(.DEST_WIDTH(DW)) bus ();

   memory_access_unit #(.MEM_DEPTH(33), .DEST_WIDTH(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .busy    (busy),
      .state_o (state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[32] = 8'h11;
      bus.memDataOutput = 8'h00;
   end

   always @(posedge clk) begin
      if (bus.memEnable) begin
         mem[bus.memAddress] <= bus.memDataInput;
         wr_count <= wr_count + 1;
      end else begin
         bus.memDataOutput <= mem[bus.memDataInput];
      end
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents a request in IDLE; returns just after the accepting edge
   task automatic send(input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] data, input logic [DW-1:0] dest);
      bus.reqValid   = 1'b1;
      bus.reqOp      = op;
      bus.reqAddress = addr;
      bus.reqData    = data;
      bus.reqDest    = dest;
      step();
      bus.reqValid   = 1'b0;
      #1;
   endtask

   // Completes the response handshake from RESP
   task automatic consume(input string tag);
      bus.rspReady = 1'b1;
      step();
      bus.rspReady = 1'b0;
      #1;
      check({tag, "_rspvalid_low"}, 32'(bus.rspValid), 32'd0);
      check({tag, "_reqready_back"}, 32'(bus.reqReady), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus.reqValid   = 1'b0;
      bus.reqOp      = 2'b00;
      bus.reqAddress = 8'h00;
      bus.reqData    = 8'h00;
      bus.reqDest    = '0;
      bus.rspReady   = 1'b0;

      // Reset
      rst = 1'b0;
      step();
      step();
      check("rst_reqready", 32'(bus.reqReady), 32'd0);
      check("rst_memenable", 32'(bus.memEnable), 32'd0);
      check("rst_rspvalid", 32'(bus.rspValid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rspdata", 32'(bus.rspData), 32'd0);
      check("rst_rspdest", 32'(bus.rspDest), 32'd0);
      check("rst_rsperror", 32'(bus.rspError), 32'd0);
      check("rst_memaddr", 32'(bus.memAddress), 32'd0);
      check("rst_memdin", 32'(bus.memDataInput), 32'd0);
      rst = 1'b1;
      #1;
      check("idle_reqready", 32'(bus.reqReady), 32'd1);
      check("idle_state", 32'(state), 32'(ST_IDLE));

      // Store 0xA7 to address 5
      send(2'b01, 8'd5, 8'hA7, 3'd1);
      check("st_state", 32'(state), 32'(ST_WRITE));
      check("st_memenable", 32'(bus.memEnable), 32'd1);
      check("st_memaddr", 32'(bus.memAddress), 32'd5);
      check("st_memdin", 32'(bus.memDataInput), 32'hA7);
      check("st_rspvalid_early", 32'(bus.rspValid), 32'd0);
      check("st_reqready_busy", 32'(bus.reqReady), 32'd0);
      step();
      check("st_rspvalid", 32'(bus.rspValid), 32'd1);
      check("st_memenable_off", 32'(bus.memEnable), 32'd0);
      check("st_rspdata", 32'(bus.rspData), 32'd0);
      check("st_rsperror", 32'(bus.rspError), 32'd0);
      check("st_rspdest", 32'(bus.rspDest), 32'd1);
      check("st_writes", 32'(wr_count), 32'd1);
      consume("st");

      // Load address 5, dest 3
      send(2'b00, 8'd5, 8'h00, 3'd3);
      check("ld_read_state", 32'(state), 32'(ST_READ));
      check("ld_read_en", 32'(bus.memEnable), 32'd0);
      check("ld_read_din", 32'(bus.memDataInput), 32'd5);
      check("ld_read_addr", 32'(bus.memAddress), 32'd0);
      check("ld_read_rspvalid", 32'(bus.rspValid), 32'd0);
      step();
      check("ld_cap_state", 32'(state), 32'(ST_CAPTURE));
      check("ld_cap_en", 32'(bus.memEnable), 32'd0);
      check("ld_cap_din", 32'(bus.memDataInput), 32'd5);
      check("ld_cap_rspvalid", 32'(bus.rspValid), 32'd0);
      step();
      check("ld_rspvalid", 32'(bus.rspValid), 32'd1);
      check("ld_rspdata", 32'(bus.rspData), 32'hA7);
      check("ld_rspdest", 32'(bus.rspDest), 32'd3);
      check("ld_rsperror", 32'(bus.rspError), 32'd0);
      check("ld_busy", 32'(busy), 32'd1);
      consume("ld");

      // Swap at address 32 (holds 0x11) with 0x22
      send(2'b10, 8'd32, 8'h22, 3'd5);
      check("sw_read_din", 32'(bus.memDataInput), 32'd32);
      step();
      check("sw_cap_state", 32'(state), 32'(ST_CAPTURE));
      step();
      check("sw_write_state", 32'(state), 32'(ST_WRITE));
      check("sw_write_en", 32'(bus.memEnable), 32'd1);
      check("sw_write_addr", 32'(bus.memAddress), 32'd32);
      check("sw_write_din", 32'(bus.memDataInput), 32'h22);
      check("sw_write_rspvalid", 32'(bus.rspValid), 32'd0);
      step();
      check("sw_rspvalid", 32'(bus.rspValid), 32'd1);
      check("sw_rspdata", 32'(bus.rspData), 32'h11);
      check("sw_rspdest", 32'(bus.rspDest), 32'd5);
      check("sw_writes", 32'(wr_count), 32'd2);
      consume("sw");

      // Load address 32 sees the swapped-in value
      send(2'b00, 8'd32, 8'h00, 3'd2);
      step();
      step();
      check("ld32_rspvalid", 32'(bus.rspValid), 32'd1);
      check("ld32_rspdata", 32'(bus.rspData), 32'h22);
      check("ld32_rspdest", 32'(bus.rspDest), 32'd2);
      consume("ld32");

      // Errors: load @33, store @255, reserved opcode
      wr_snap = wr_count;
      send(2'b00, 8'd33, 8'h5A, 3'd4);
      check("e33_memenable", 32'(bus.memEnable), 32'd0);
      check("e33_rspvalid", 32'(bus.rspValid), 32'd1);
      check("e33_rsperror", 32'(bus.rspError), 32'd1);
      check("e33_rspdata", 32'(bus.rspData), 32'd0);
      check("e33_rspdest", 32'(bus.rspDest), 32'd4);
      consume("e33");
      send(2'b01, 8'd255, 8'hC3, 3'd6);
      check("e255_memenable", 32'(bus.memEnable), 32'd0);
      check("e255_rspvalid", 32'(bus.rspValid), 32'd1);
      check("e255_rsperror", 32'(bus.rspError), 32'd1);
      check("e255_rspdata", 32'(bus.rspData), 32'd0);
      consume("e255");
      send(2'b11, 8'd5, 8'h3C, 3'd7);
      check("eop_memenable", 32'(bus.memEnable), 32'd0);
      check("eop_rspvalid", 32'(bus.rspValid), 32'd1);
      check("eop_rsperror", 32'(bus.rspError), 32'd1);
      check("eop_rspdata", 32'(bus.rspData), 32'd0);
      consume("eop");
      check("err_no_writes", 32'(wr_count), 32'(wr_snap));

      // Backpressure: load @5, then hold rspReady low 4 cycles with a pending request
      send(2'b00, 8'd5, 8'h00, 3'd6);
      step();
      step();
      bus.reqValid   = 1'b1;
      bus.reqOp      = 2'b01;
      bus.reqAddress = 8'd7;
      bus.reqData    = 8'h99;
      bus.reqDest    = 3'd1;
      wr_snap = wr_count;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("bp_rspvalid", 32'(bus.rspValid), 32'd1);
         check("bp_rspdata", 32'(bus.rspData), 32'hA7);
         check("bp_rspdest", 32'(bus.rspDest), 32'd6);
         check("bp_rsperror", 32'(bus.rspError), 32'd0);
         check("bp_reqready", 32'(bus.reqReady), 32'd0);
         check("bp_state", 32'(state), 32'(ST_RESP));
         step();
      end
      bus.rspReady = 1'b1;
      step();
      bus.rspReady = 1'b0;
      #1;
      check("bp_after_hs_state", 32'(state), 32'(ST_IDLE));
      check("bp_after_hs_reqready", 32'(bus.reqReady), 32'd1);
      check("bp_after_hs_writes", 32'(wr_count), 32'(wr_snap));
      step();
      bus.reqValid = 1'b0;
      #1;
      check("bp_next_state", 32'(state), 32'(ST_WRITE));
      check("bp_next_memaddr", 32'(bus.memAddress), 32'd7);
      check("bp_next_memdin", 32'(bus.memDataInput), 32'h99);
      step();
      check("bp_next_rspvalid", 32'(bus.rspValid), 32'd1);
      check("bp_next_rspdest", 32'(bus.rspDest), 32'd1);
      consume("bp_next");

      // Reset during the WRITE cycle of a swap at address 5
      send(2'b10, 8'd5, 8'h55, 3'd2);
      step();
      step();
      check("rw_state", 32'(state), 32'(ST_WRITE));
      check("rw_memenable", 32'(bus.memEnable), 32'd1);
      wr_snap = wr_count;
      rst = 1'b0;
      #1;
      check("rw_memenable_forced", 32'(bus.memEnable), 32'd0);
      check("rw_rspvalid_forced", 32'(bus.rspValid), 32'd0);
      step();
      check("rw_state_idle", 32'(state), 32'(ST_IDLE));
      check("rw_busy", 32'(busy), 32'd0);
      check("rw_memaddr", 32'(bus.memAddress), 32'd0);
      check("rw_no_write", 32'(wr_count), 32'(wr_snap));
      rst = 1'b1;
      #1;
      check("rw_reqready", 32'(bus.reqReady), 32'd1);
      check("rw_rspvalid", 32'(bus.rspValid), 32'd0);
      step();
      check("rw_rspvalid_stays", 32'(bus.rspValid), 32'd0);
      send(2'b00, 8'd5, 8'h00, 3'd0);
      step();
      step();
      check("rw_ld_rspdata", 32'(bus.rspData), 32'hA7);
      consume("rw_ld");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
